// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship turn controller.
// Provides the FSM state enum, word codes, glyph bytes and the glyph lookup.
package battleship_pkg;

  typedef enum logic [3:0] {
    SETUP,
    A_TURN,
    A_CHECK,
    A_EVAL,
    B_TURN,
    B_CHECK,
    B_EVAL,
    A_WIN,
    B_WIN
  } state_t;

  localparam logic [2:0] W_LOAD = 3'd0;
  localparam logic [2:0] W_FIRE = 3'd1;
  localparam logic [2:0] W_HOLD = 3'd2;
  localparam logic [2:0] W_WIN  = 3'd3;
  localparam logic [2:0] W_LOSE = 3'd4;

  // Active-low, bit order {dp,g,f,e,d,c,b,a}; dp always off.
  localparam logic [7:0] GLYPH_L     = 8'hC7;
  localparam logic [7:0] GLYPH_LO    = 8'hA3;
  localparam logic [7:0] GLYPH_A     = 8'h88;
  localparam logic [7:0] GLYPH_D     = 8'hA1;
  localparam logic [7:0] GLYPH_F     = 8'h8E;
  localparam logic [7:0] GLYPH_I     = 8'hFB;
  localparam logic [7:0] GLYPH_R     = 8'hAF;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_H     = 8'h89;
  localparam logic [7:0] GLYPH_Y     = 8'h91;
  localparam logic [7:0] GLYPH_S     = 8'h92;
  localparam logic [7:0] GLYPH_O     = 8'hC0;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  // pos 0 is the leftmost character of the word.
  function automatic logic [7:0] glyph(
    input logic [2:0] w,
    input logic [1:0] pos
  );
    logic [31:0] s;
    case (w)
      W_LOAD:  s = {GLYPH_L, GLYPH_LO, GLYPH_A, GLYPH_D};
      W_FIRE:  s = {GLYPH_F, GLYPH_I, GLYPH_R, GLYPH_E};
      W_HOLD:  s = {GLYPH_H, GLYPH_LO, GLYPH_L, GLYPH_D};
      W_WIN:   s = {GLYPH_Y, GLYPH_E, GLYPH_S, GLYPH_BLANK};
      W_LOSE:  s = {GLYPH_L, GLYPH_O, GLYPH_S, GLYPH_E};
      default: s = {4{GLYPH_BLANK}};
    endcase
    return s[31 - 8*pos -: 8];
  endfunction

endpackage

// File: rtl/battleship_game_ctrl_if.sv
// Board-side signal bundle for the turn controller.
// master = board/top level driving buttons & vectors; slave = controller.
interface battleship_game_ctrl_if #(
  parameter int GRID = 16
);
  logic            BTN1;
  logic            BTN2A;
  logic            BTN2B;
  logic            LivA;
  logic            LivB;
  logic            OKB;
  logic [GRID-1:0] prev_atk;
  logic [GRID-1:0] new_atk;
  logic            OKA;
  logic            ST;
  logic            LDR1A;
  logic            LDR1B;
  logic            LDR2A;
  logic            LDR2B;
  logic [2:0]      DispA;
  logic [2:0]      DispB;
  logic [7:0]      seg;
  logic [3:0]      an;

  modport master (
    output BTN1, BTN2A, BTN2B, LivA, LivB, OKB,
    output prev_atk, new_atk,
    input  OKA, ST, LDR1A, LDR1B, LDR2A, LDR2B,
    input  DispA, DispB, seg, an
  );

  modport slave (
    input  BTN1, BTN2A, BTN2B, LivA, LivB, OKB,
    input  prev_atk, new_atk,
    output OKA, ST, LDR1A, LDR1B, LDR2A, LDR2B,
    output DispA, DispB, seg, an
  );
endinterface

// File: rtl/battleship_game_ctrl_word_display.sv
// 4-digit seven-segment scanner showing one word code.
// Ports: clk_i, clr_i, word_i (code) -> seg_o (active-low), an_o (active-low).
module battleship_game_ctrl_word_display
  import battleship_pkg::*;
#(
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic [2:0] word_i,
  output logic [7:0] seg_o,
  output logic [3:0] an_o
);

  logic [REFRESH_BITS-1:0] cnt_q;
  logic [REFRESH_BITS-1:0] cnt_d;
  logic [1:0]              sel;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sel   = cnt_q[REFRESH_BITS-1 -: 2];
  // sel 0 drives the leftmost digit (an[3]).
  assign an_o  = ~(4'b1000 >> sel);
  assign seg_o = glyph(word_i, sel);

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship turn controller: setup, alternating attacks, checks, win/lose.
// Ports: clk, clr (sync reset), bus (slave modport: buttons, vectors, ctrl, display).
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int REFRESH_BITS = 17,
  parameter int GRID         = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  battleship_game_ctrl_if.slave bus
);

  state_t state_q, state_d;

  logic [GRID-1:0] diff;
  logic            oka;
  logic            st;
  logic            ldr1a, ldr1b;
  logic            ldr2a, ldr2b;
  logic [2:0]      disp_a, disp_b;

  // Valid attack: no earlier shot withdrawn and exactly one new shot.
  always_comb begin
    diff = bus.new_atk ^ bus.prev_atk;
    oka  = ((bus.prev_atk & ~bus.new_atk) == '0)
        && (diff != '0)
        && ((diff & (diff - 1'b1)) == '0);
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= SETUP;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    st      = 1'b1;
    ldr1a   = 1'b1;
    ldr1b   = 1'b1;
    ldr2a   = 1'b0;
    ldr2b   = 1'b0;
    disp_a  = W_HOLD;
    disp_b  = W_HOLD;
    unique case (state_q)
      SETUP: begin
        st     = 1'b0;
        disp_a = W_LOAD;
        disp_b = W_LOAD;
        if (bus.BTN1) state_d = A_TURN;
      end
      A_TURN: begin
        disp_a = W_FIRE;
        ldr2a  = bus.BTN2A;
        if (bus.BTN2A) state_d = A_CHECK;
      end
      A_CHECK: begin
        ldr2a = bus.BTN2A;
        if (bus.OKB) state_d = A_EVAL;
      end
      A_EVAL: begin
        // Only the defender is tested, so the attacker wins a mutual wipe.
        state_d = bus.LivB ? B_TURN : A_WIN;
      end
      B_TURN: begin
        disp_b = W_FIRE;
        ldr2b  = bus.BTN2B;
        if (bus.BTN2B) state_d = B_CHECK;
      end
      B_CHECK: begin
        ldr2b = bus.BTN2B;
        if (oka) state_d = B_EVAL;
      end
      B_EVAL: begin
        state_d = bus.LivA ? A_TURN : B_WIN;
      end
      A_WIN: begin
        disp_a = W_WIN;
        disp_b = W_LOSE;
      end
      B_WIN: begin
        disp_a = W_LOSE;
        disp_b = W_WIN;
      end
      default: state_d = SETUP;
    endcase
  end

  assign bus.OKA   = oka;
  assign bus.ST    = st;
  assign bus.LDR1A = ldr1a;
  assign bus.LDR1B = ldr1b;
  assign bus.LDR2A = ldr2a;
  assign bus.LDR2B = ldr2b;
  assign bus.DispA = disp_a;
  assign bus.DispB = disp_b;

  battleship_game_ctrl_word_display #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_disp (
    .clk_i  (clk),
    .clr_i  (clr),
    .word_i (disp_a),
    .seg_o  (bus.seg),
    .an_o   (bus.an)
  );

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed bench for battleship_game_ctrl with a short refresh counter.
// Walks setup, both turns, both wins, checker vectors, clr and scanning.
module tb_battleship_game_ctrl;

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  battleship_game_ctrl_if #(.GRID(16)) bus ();

  battleship_game_ctrl #(
    .REFRESH_BITS(4),
    .GRID(16)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_left(input string tag);
    for (int k = 0; k < 16 && bus.an !== 4'b0111; k++) step();
    chk(tag, {28'd0, bus.an}, 32'h7);
  endtask

  logic [3:0] an_exp [4];
  logic [7:0] ld_exp [4];

  initial begin
    an_exp = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    ld_exp = '{8'hC7, 8'hA3, 8'h88, 8'hA1};
    clr = 1'b1;
    bus.BTN1 = 0; bus.BTN2A = 0; bus.BTN2B = 0;
    bus.LivA = 1; bus.LivB = 1; bus.OKB = 0;
    bus.prev_atk = 16'h0000; bus.new_atk = 16'h0000;
    step();
    step();
    chk("rst_st", {31'd0, bus.ST}, 0);
    chk("rst_dispa", {29'd0, bus.DispA}, 0);
    chk("rst_dispb", {29'd0, bus.DispB}, 0);
    chk("rst_ldr1", {30'd0, bus.LDR1A, bus.LDR1B}, 3);
    chk("rst_ldr2", {30'd0, bus.LDR2A, bus.LDR2B}, 0);
    chk("rst_an", {28'd0, bus.an}, 32'h7);
    clr = 1'b0;

    // Scan through "LoAd" in SETUP, counter starts at 0.
    for (int i = 0; i < 16; i++) begin
      chk("scan_an", {28'd0, bus.an}, {28'd0, an_exp[i/4]});
      chk("scan_seg", {24'd0, bus.seg}, {24'd0, ld_exp[i/4]});
      chk("scan_dp", {31'd0, bus.seg[7]}, 1);
      step();
    end
    chk("setup_hold", {29'd0, bus.DispA}, 0);

    // Checker vectors.
    bus.prev_atk = 16'h0001; bus.new_atk = 16'h0003; #1;
    chk("oka_one", {31'd0, bus.OKA}, 1);
    bus.new_atk = 16'h0007; #1;
    chk("oka_two", {31'd0, bus.OKA}, 0);
    bus.new_atk = 16'h0002; #1;
    chk("oka_drop", {31'd0, bus.OKA}, 0);
    bus.new_atk = 16'h0001; #1;
    chk("oka_eq", {31'd0, bus.OKA}, 0);
    bus.prev_atk = 16'h0000; bus.new_atk = 16'h8000; #1;
    chk("oka_msb", {31'd0, bus.OKA}, 1);
    bus.prev_atk = 16'h0000; bus.new_atk = 16'h0000; #1;

    // Leave setup.
    bus.BTN1 = 1; step(); bus.BTN1 = 0;
    chk("a_turn_st", {31'd0, bus.ST}, 1);
    chk("a_turn_da", {29'd0, bus.DispA}, 1);
    chk("a_turn_db", {29'd0, bus.DispB}, 2);
    chk("a_turn_ldr2a", {31'd0, bus.LDR2A}, 0);
    wait_left("a_turn_left");
    chk("a_turn_segF", {24'd0, bus.seg}, 32'h8E);
    chk("a_turn_still", {29'd0, bus.DispA}, 1);

    // A fires (Mealy load).
    bus.BTN2A = 1; #1;
    chk("a_fire_ldr2a", {31'd0, bus.LDR2A}, 1);
    step(); bus.BTN2A = 0; #1;
    chk("a_chk_da", {29'd0, bus.DispA}, 2);
    chk("a_chk_db", {29'd0, bus.DispB}, 2);
    chk("a_chk_ldr2a", {31'd0, bus.LDR2A}, 0);
    chk("a_chk_ldr1", {30'd0, bus.LDR1A, bus.LDR1B}, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("a_chk_wait", {26'd0, bus.DispA, bus.DispB}, 32'h12);
    end
    bus.BTN2A = 1; #1;
    chk("a_chk_resub", {31'd0, bus.LDR2A}, 1);
    bus.BTN2A = 0; #1;
    bus.OKB = 1; step(); bus.OKB = 0;
    step();
    chk("b_turn_da", {29'd0, bus.DispA}, 2);
    chk("b_turn_db", {29'd0, bus.DispB}, 1);
    chk("b_turn_ldr2b", {31'd0, bus.LDR2B}, 0);

    // B fires, checker initially rejects.
    bus.BTN2B = 1; #1;
    chk("b_fire_ldr2b", {31'd0, bus.LDR2B}, 1);
    step(); bus.BTN2B = 0;
    bus.prev_atk = 16'h0001; bus.new_atk = 16'h0001;
    step(); step();
    chk("b_chk_wait", {26'd0, bus.DispA, bus.DispB}, 32'h12);
    bus.new_atk = 16'h0003; bus.LivA = 0;
    step();
    step();
    chk("b_win_da", {29'd0, bus.DispA}, 4);
    chk("b_win_db", {29'd0, bus.DispB}, 3);
    bus.new_atk = 16'h0001; bus.LivA = 1;
    bus.BTN1 = 1; bus.BTN2A = 1; bus.BTN2B = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("b_win_hold", {26'd0, bus.DispA, bus.DispB}, 32'h23);
    end
    bus.BTN1 = 0; bus.BTN2A = 0; bus.BTN2B = 0;
    wait_left("b_win_left");
    chk("b_win_segL", {24'd0, bus.seg}, 32'hC7);

    // Restart, reach B_CHECK, then clear.
    clr = 1; step(); clr = 0;
    chk("clr1_da", {29'd0, bus.DispA}, 0);
    bus.BTN1 = 1; step(); bus.BTN1 = 0;
    bus.BTN2A = 1; step(); bus.BTN2A = 0;
    bus.OKB = 1; step(); bus.OKB = 0;
    step();
    bus.BTN2B = 1; step(); bus.BTN2B = 0;
    chk("b_chk2", {26'd0, bus.DispA, bus.DispB}, 32'h12);
    bus.BTN2A = 1; bus.BTN2B = 1; clr = 1;
    step();
    chk("clr_st", {31'd0, bus.ST}, 0);
    chk("clr_da", {29'd0, bus.DispA}, 0);
    chk("clr_ldr2", {30'd0, bus.LDR2A, bus.LDR2B}, 0);
    chk("clr_an", {28'd0, bus.an}, 32'h7);
    clr = 0; bus.BTN2A = 0; bus.BTN2B = 0;

    // Both fleets gone in A_EVAL: attacker A wins.
    bus.BTN1 = 1; step(); bus.BTN1 = 0;
    bus.BTN2A = 1; step(); bus.BTN2A = 0;
    bus.LivA = 0; bus.LivB = 0;
    bus.OKB = 1; step(); bus.OKB = 0;
    step();
    chk("a_win_da", {29'd0, bus.DispA}, 3);
    chk("a_win_db", {29'd0, bus.DispB}, 4);
    step(); step();
    chk("a_win_hold", {26'd0, bus.DispA, bus.DispB}, 32'h1C);
    wait_left("a_win_left");
    chk("a_win_segY", {24'd0, bus.seg}, 32'h91);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
